// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station. Collapsing queue of decoded instructions
// (index 0 = oldest) that snoops the ROB result broadcast for pending
// operands and dispatches the oldest fully-ready entry into a registered
// output stage.
module alu_rs #(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 6,
    parameter int UNIT_W = 4,
    parameter int EXCP_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_IDSUE_valid,
    input  logic [CNT_W-1:0]          i_IDSUE_cnt,
    input  logic [31:0]               i_IDSUE_pc,
    input  logic [6:0]                i_IDSUE_opcode,
    input  logic [2:0]                i_IDSUE_funct3,
    input  logic [31:0]               i_IDSUE_imm,
    input  logic [4:0]                i_IDSUE_rd,
    input  logic [EXCP_W-1:0]         i_IDSUE_excp,
    input  logic [UNIT_W-1:0]         i_IDSUE_u1,
    input  logic [UNIT_W-1:0]         i_IDSUE_u2,
    input  logic [31:0]               i_IDSUE_d1,
    input  logic [31:0]               i_IDSUE_d2,
    output logic                      o_IDSUE_full,
    input  logic [UNIT_W-1:0]         i_ROB_u,
    input  logic [31:0]               i_ROB_udata,
    input  logic                      i_ROB_flush,
    input  logic                      i_ALU_ready,
    output logic                      o_ALU_valid,
    output logic [CNT_W-1:0]          o_ALU_cnt,
    output logic [31:0]               o_ALU_pc,
    output logic [6:0]                o_ALU_opcode,
    output logic [2:0]                o_ALU_funct3,
    output logic [31:0]               o_ALU_d1,
    output logic [31:0]               o_ALU_d2,
    output logic [31:0]               o_ALU_imm,
    output logic [4:0]                o_ALU_rd,
    output logic [EXCP_W-1:0]         o_ALU_excp,
    output logic [$clog2(DEPTH):0]    o_RS_count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic              valid;
        logic [CNT_W-1:0]  cnt;
        logic [31:0]       pc;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [31:0]       imm;
        logic [4:0]        rd;
        logic [EXCP_W-1:0] excp;
        logic [UNIT_W-1:0] u1;
        logic [UNIT_W-1:0] u2;
        logic [31:0]       d1;
        logic [31:0]       d2;
        logic              r1;
        logic              r2;
    } entry_t;

    entry_t          ent     [DEPTH];
    entry_t          woke    [DEPTH];
    entry_t          ent_nxt [DEPTH];
    entry_t          new_ent;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   ins_idx;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic            do_disp;
    logic            do_ins;
    logic            rob_live;

    assign o_IDSUE_full = (count == CW'(DEPTH));
    assign o_RS_count   = count;
    assign rob_live     = (i_ROB_u != '0);
    assign do_ins       = i_IDSUE_valid && !o_IDSUE_full;
    assign do_disp      = sel_found && (!o_ALU_valid || i_ALU_ready);
    assign ins_idx      = count - CW'(do_disp);
    assign count_nxt    = count + CW'(do_ins) - CW'(do_disp);

    // Oldest entry whose registered ready flags are both set
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent[i].valid && ent[i].r1 && ent[i].r2) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Build the incoming entry: bypass same-cycle broadcast, then opcode overrides
    always_comb begin
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.cnt    = i_IDSUE_cnt;
        new_ent.pc     = i_IDSUE_pc;
        new_ent.opcode = i_IDSUE_opcode;
        new_ent.funct3 = i_IDSUE_funct3;
        new_ent.imm    = i_IDSUE_imm;
        new_ent.rd     = i_IDSUE_rd;
        new_ent.excp   = i_IDSUE_excp;
        new_ent.u1     = i_IDSUE_u1;
        new_ent.u2     = i_IDSUE_u2;
        new_ent.d1     = i_IDSUE_d1;
        new_ent.d2     = i_IDSUE_d2;
        new_ent.r1     = (i_IDSUE_u1 == '0);
        new_ent.r2     = (i_IDSUE_u2 == '0);
        if (!new_ent.r1 && rob_live && (i_IDSUE_u1 == i_ROB_u)) begin
            new_ent.r1 = 1'b1;
            new_ent.d1 = i_ROB_udata;
        end
        if (!new_ent.r2 && rob_live && (i_IDSUE_u2 == i_ROB_u)) begin
            new_ent.r2 = 1'b1;
            new_ent.d2 = i_ROB_udata;
        end
        case (i_IDSUE_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                new_ent.r1 = 1'b1;
                new_ent.d1 = '0;
                new_ent.r2 = 1'b1;
                new_ent.d2 = '0;
            end
            OPC_OP_IMM, OPC_JALR: begin
                new_ent.r2 = 1'b1;
                new_ent.d2 = '0;
            end
            default: ;
        endcase
    end

    // Next queue contents: wakeup, collapse over the dispatched slot, append at tail
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent[i];
            if (ent[i].valid && rob_live) begin
                if (!ent[i].r1 && ent[i].u1 == i_ROB_u) begin
                    woke[i].r1 = 1'b1;
                    woke[i].d1 = i_ROB_udata;
                end
                if (!ent[i].r2 && ent[i].u2 == i_ROB_u) begin
                    woke[i].r2 = 1'b1;
                    woke[i].d2 = i_ROB_udata;
                end
            end
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_nxt[i] = (do_disp && i >= int'(sel_idx)) ? woke[i+1] : woke[i];
        end
        ent_nxt[DEPTH-1] = do_disp ? '0 : woke[DEPTH-1];
        if (do_ins) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(ins_idx)) ent_nxt[i] = new_ent;
            end
        end
    end

    // Queue state and registered ALU output stage; flush beats everything but reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            count        <= '0;
            o_ALU_valid  <= 1'b0;
            o_ALU_cnt    <= '0;
            o_ALU_pc     <= '0;
            o_ALU_opcode <= '0;
            o_ALU_funct3 <= '0;
            o_ALU_d1     <= '0;
            o_ALU_d2     <= '0;
            o_ALU_imm    <= '0;
            o_ALU_rd     <= '0;
            o_ALU_excp   <= '0;
        end else if (i_ROB_flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            count       <= '0;
            o_ALU_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
            count <= count_nxt;
            if (do_disp) begin
                o_ALU_valid  <= 1'b1;
                o_ALU_cnt    <= ent[sel_idx].cnt;
                o_ALU_pc     <= ent[sel_idx].pc;
                o_ALU_opcode <= ent[sel_idx].opcode;
                o_ALU_funct3 <= ent[sel_idx].funct3;
                o_ALU_d1     <= ent[sel_idx].d1;
                o_ALU_d2     <= ent[sel_idx].d2;
                o_ALU_imm    <= ent[sel_idx].imm;
                o_ALU_rd     <= ent[sel_idx].rd;
                o_ALU_excp   <= ent[sel_idx].excp;
            end else if (i_ALU_ready) begin
                o_ALU_valid <= 1'b0;
            end
        end
    end
endmodule
